// File: rtl/rom_accum_sequencer.sv
// rom_accum_sequencer
//
// Reads a contiguous range of a synchronous-read ROM and sums the returned
// words into an accumulator with a sticky carry-out flag.
//
// Ports:
//   clk        clock
//   rst        asynchronous, active-low reset
//   start      run request, sampled only in IDLE
//   base_addr  first ROM address, latched on an accepted start
//   count      number of words to read (0..2^ADDR_W), latched on an accepted start
//   stall      suppresses issuing a read this cycle (RUN only)
//   abort      cancels the current run (RUN or DRAIN)
//   rom_addr   registered ROM address
//   rom_data   ROM word, valid RD_LAT cycles after its address was issued
//   busy       high in RUN and DRAIN
//   done       one-cycle pulse in the cycle the final sum is visible
//   sum        accumulator
//   overflow   sticky carry-out of the accumulator
//   state_dbg  current FSM state (IDLE=0, RUN=1, DRAIN=2, DONE=3)
//
// Handshake: start is accepted only when the block is idle (busy=0, done=0)
// and abort is low; it is not queued otherwise. After acceptance busy stays
// high until the cycle before done. done is high for exactly one cycle and
// sum/overflow are final from that cycle until the next accepted start.
// An aborted run drops busy without any done pulse.

module rom_accum_sequencer #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int ACC_W  = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  input  logic              stall,
  input  logic              abort,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  sum,
  output logic              overflow,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state, state_nx;
  logic [ADDR_W:0]     remaining;
  logic [RD_LAT-1:0]   vpipe, vpipe_shift, vpipe_nx;
  logic                accept, kill, issue, data_valid;
  logic [ACC_W:0]      add_full;

  // Zero-extend the ROM word to ACC_W+1 bits so the top bit is the carry.
  assign add_full = {1'b0, sum} + {{(ACC_W + 1 - DATA_W){1'b0}}, rom_data};

  always_comb begin
    accept      = 1'b0;
    kill        = 1'b0;
    issue       = 1'b0;
    state_nx    = state;
    busy        = 1'b0;
    done        = 1'b0;
    // Pipeline contents after this cycle's shift, before any new issue.
    vpipe_shift = vpipe << 1;

    case (state)
      S_IDLE: begin
        accept = start && !abort;
        if (accept) state_nx = (count == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (abort) begin
          kill     = 1'b1;
          state_nx = S_IDLE;
        end else if (!stall) begin
          issue = 1'b1;
          if (remaining == (ADDR_W + 1)'(1)) state_nx = S_DRAIN;
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (abort) begin
          kill     = 1'b1;
          state_nx = S_IDLE;
        end else if (vpipe_shift == '0) begin
          // The last in-flight word is being accumulated this cycle.
          state_nx = S_DONE;
        end
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase

    vpipe_nx    = vpipe_shift;
    vpipe_nx[0] = issue;
    if (kill) vpipe_nx = '0;

    // A word arriving in the abort cycle is treated as in flight and dropped.
    data_valid = vpipe[RD_LAT-1] && !kill;
  end

  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      rom_addr  <= '0;
      remaining <= '0;
      vpipe     <= '0;
      sum       <= '0;
      overflow  <= 1'b0;
    end else begin
      state <= state_nx;
      vpipe <= vpipe_nx;

      if (accept) begin
        rom_addr  <= base_addr;
        remaining <= count;
      end else if (issue) begin
        rom_addr  <= rom_addr + ADDR_W'(1);
        remaining <= remaining - (ADDR_W + 1)'(1);
      end

      if (accept) begin
        sum      <= '0;
        overflow <= 1'b0;
      end else if (data_valid) begin
        sum      <= add_full[ACC_W-1:0];
        overflow <= overflow | add_full[ACC_W];
      end
    end
  end

endmodule

// File: tb/tb_rom_accum_sequencer.sv
// Bench for rom_accum_sequencer: directed scenarios plus randomized jobs,
// with expected results pushed to a queue and checked by a done monitor.

module tb_rom_accum_sequencer;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int ACC_W  = 32;
  localparam int RD_LAT = 1;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int EW     = 32 + 1 + ACC_W;

  logic              clk;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   count;
  logic              stall;
  logic              abort;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              busy;
  logic              done;
  logic [ACC_W-1:0]  sum;
  logic              overflow;
  logic [1:0]        state_dbg;

  rom_accum_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACC_W(ACC_W), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .count(count), .stall(stall), .abort(abort), .rom_addr(rom_addr),
    .rom_data(rom_data), .busy(busy), .done(done), .sum(sum),
    .overflow(overflow), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset / cycle counter ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- ROM model ----------------
  logic [DATA_W-1:0] rom [DEPTH];
  logic [DATA_W-1:0] rd_pipe [RD_LAT];

  always @(posedge clk) begin
    rd_pipe[0] <= rom[rom_addr];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign rom_data = rd_pipe[RD_LAT-1];

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: sum of n consecutive ROM words from base (address wraps),
  // sticky carry set if any partial sum exceeds ACC_W bits.
  function automatic logic [ACC_W:0] ref_sum(input int base, input int n);
    logic [ACC_W:0]   t;
    logic [ACC_W-1:0] s;
    logic             o;
    s = '0;
    o = 1'b0;
    for (int i = 0; i < n; i++) begin
      t = {1'b0, s} + {{(ACC_W + 1 - DATA_W){1'b0}}, rom[(base + i) % DEPTH]};
      o = o | t[ACC_W];
      s = t[ACC_W-1:0];
    end
    return {o, s};
  endfunction

  // Monitor: every done pulse must match the oldest expected run result.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst && done) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no done", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("done_cycle", 64'(cyc), 64'(e[EW-1:ACC_W+1]));
        chk("done_sum", 64'(sum), 64'(e[ACC_W-1:0]));
        chk("done_overflow", 64'(overflow), 64'(e[ACC_W]));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic idle_inputs();
    start = 1'b0;
    stall = 1'b0;
    abort = 1'b0;
  endtask

  // One job. Stalls: forced burst [burst_at, burst_at+burst_len) plus random
  // with probability stall_pct%. abort_at>0 raises abort in that relative cycle.
  task automatic run_job(input int base, input int n, input int stall_pct,
                         input int burst_at, input int burst_len,
                         input int abort_at, input bit hold_start);
    bit             stv[$];
    int             issue_rel[$];
    int             rel, run_len, done_rel, last, c0, nidx, k;
    bit             s;
    logic [ACC_W:0] r;

    // Decide the stall pattern and derive the schedule from it.
    rel = 1;
    while (issue_rel.size() < n) begin
      s = (rel >= burst_at && rel < burst_at + burst_len) ||
          (stall_pct > 0 && $urandom_range(99) < stall_pct);
      stv.push_back(s);
      if (!s) issue_rel.push_back(rel);
      rel++;
    end
    run_len  = rel - 1;
    done_rel = (n == 0) ? 1 : run_len + RD_LAT + 1;

    if (abort_at == 0) begin
      r = ref_sum(base, n);
    end else begin
      k = 0;
      foreach (issue_rel[j]) if (issue_rel[j] + RD_LAT < abort_at) k++;
      r = ref_sum(base, k);
    end

    @(posedge clk);
    #1;
    c0        = cyc;
    start     = 1'b1;
    base_addr = ADDR_W'(base);
    count     = (ADDR_W + 1)'(n);
    stall     = 1'b0;
    abort     = 1'b0;
    if (abort_at == 0) exp_q.push_back({32'(c0 + done_rel), r});

    last = (abort_at != 0) ? abort_at + 2 : done_rel + 1;
    nidx = 0;
    for (int i = 1; i <= last; i++) begin
      @(posedge clk);
      #1;
      start = hold_start && (i <= done_rel);
      stall = (i <= run_len) ? stv[i-1] : 1'($urandom_range(1));
      abort = (i == abort_at);
      @(negedge clk);
      chk("busy", 64'(busy), 64'((abort_at != 0) ? (i <= abort_at) : (i < done_rel)));
      if (i <= run_len && !stv[i-1] && (abort_at == 0 || i < abort_at)) begin
        chk("rom_addr", 64'(rom_addr), 64'((base + nidx) % DEPTH));
        nidx++;
      end
    end
    idle_inputs();

    // Result holds in IDLE (final for normal runs, partial after abort).
    chk("hold_sum", 64'(sum), 64'(r[ACC_W-1:0]));
    chk("hold_overflow", 64'(overflow), 64'(r[ACC_W]));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int b, n, p;
    rst       = 1'b0;
    base_addr = '0;
    count     = '0;
    idle_inputs();
    for (int i = 0; i < DEPTH; i++) rom[i] = DATA_W'(i + 1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rom_addr", 64'(rom_addr), 64'(0));
    chk("rst_sum", 64'(sum), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_overflow", 64'(overflow), 64'(0));
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // 200 words of i+1: 20100, done at +202
    run_job(0, 200, 0, 0, 0, 0, 0);
    chk("sum_20100", 64'(sum), 64'(20100));
    // same with a 5-cycle stall burst mid-run: done at +207
    run_job(0, 200, 0, 100, 5, 0, 0);

    // address wrap: 250..255, 0..3 of rom[i]=i -> 1521
    for (int i = 0; i < DEPTH; i++) rom[i] = DATA_W'(i);
    run_job(250, 10, 0, 0, 0, 0, 0);
    chk("sum_1521", 64'(sum), 64'(1521));

    // carry out, then cleared by the next start
    rom[0] = '1;
    rom[1] = '1;
    rom[5] = DATA_W'(1);
    run_job(0, 2, 0, 0, 0, 0, 0);
    run_job(5, 1, 0, 0, 0, 0, 0);

    // abort and start together in IDLE: start ignored, sum keeps 1
    @(posedge clk);
    #1;
    start     = 1'b1;
    abort     = 1'b1;
    base_addr = '0;
    count     = (ADDR_W + 1)'(5);
    @(posedge clk);
    #1;
    idle_inputs();
    repeat (3) begin
      @(negedge clk);
      chk("abort_start_busy", 64'(busy), 64'(0));
    end
    chk("abort_start_sum", 64'(sum), 64'(1));

    // count=0: done one cycle after start, sum 0
    run_job(7, 0, 0, 0, 0, 0, 0);

    // start held high through a 200-word run: one done only
    for (int i = 0; i < DEPTH; i++) rom[i] = DATA_W'(i + 1);
    run_job(0, 200, 0, 0, 0, 0, 1);

    // abort in cycle 50: words arriving before cycle 50 are kept
    run_job(0, 200, 0, 0, 0, 50, 0);

    // reset mid-run: outputs go to zero at once, no done
    @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = ADDR_W'(17);
    count     = (ADDR_W + 1)'(200);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (30) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_rom_addr", 64'(rom_addr), 64'(0));
    chk("midrst_sum", 64'(sum), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_done", 64'(done), 64'(0));
    chk("midrst_overflow", 64'(overflow), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("postrst_busy", 64'(busy), 64'(0));
    end

    // randomized jobs, including full-depth counts and random data
    for (int j = 0; j < 20; j++) begin
      for (int i = 0; i < DEPTH; i++) rom[i] = $urandom;
      b = $urandom_range(DEPTH - 1);
      n = (j % 5 == 4) ? DEPTH : $urandom_range(0, DEPTH);
      p = $urandom_range(0, 50);
      run_job(b, n, p, 0, 0, 0, 0);
    end

    repeat (4) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL missing_done: got %0d runs without done, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
